// File: rtl/charchk_pkg.sv
// Shared types for the character generator / checker link:
// active-low truth levels, the byte type and the checker state encoding.
package charchk_pkg;

  localparam logic nT = 1'b0;
  localparam logic nF = 1'b1;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    HUNT = 2'd1,
    LOCK = 2'd2
  } state_t;

endpackage

// File: rtl/charchk_if.sv
// Active-low valid/ready byte link between the character generator (master)
// and the checker (slave).
interface charchk_if;
  import charchk_pkg::*;

  logic  valid_n;
  byte_t port;
  logic  ready_n;

  modport master (output valid_n, output port, input ready_n);
  modport slave  (input valid_n, input port, output ready_n);

endinterface

// File: rtl/charchk_sat_counter.sv
// Statistics counter that sticks at all-ones; a synchronous clear wins
// over an increment in the same cycle.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inc,
  input  logic            clr,
  output logic [CNTW-1:0] cnt
);

  localparam logic [CNTW-1:0] ONE = CNTW'(1);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/charchk.sv
// Far-end checker for the character generator: pulls bytes, locks onto the
// FIRSTCHAR..LASTCHAR cycle and keeps good-byte, wrap and error statistics.
module charchk
  import charchk_pkg::*;
#(
  parameter byte_t FIRSTCHAR = "a",
  parameter byte_t LASTCHAR  = "z",
  parameter int    CNTW      = 16
) (
  input  logic            clk,
  input  logic            n_rst,
  charchk_if.slave        bus,
  input  logic            enable,
  input  logic            throttle,
  input  logic            clear,
  output logic            locked,
  output logic            err_pulse,
  output logic [CNTW-1:0] byte_cnt,
  output logic [CNTW-1:0] wrap_cnt,
  output logic [CNTW-1:0] err_cnt
);

  state_t state, state_nxt;
  byte_t  exp_chr, exp_nxt;
  logic   accept;
  logic   byte_inc, wrap_inc, err_inc;

  function automatic byte_t next_char(input byte_t c);
    return (c == LASTCHAR) ? FIRSTCHAR : c + 8'd1;
  endfunction

  // ready_n is the registered request, so in OFF it is already high and no
  // handshake can complete there.
  assign accept = (bus.valid_n == nT) && (bus.ready_n == nT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= OFF;
      exp_chr     <= FIRSTCHAR;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      bus.ready_n <= nF;
    end else begin
      state       <= state_nxt;
      exp_chr     <= exp_nxt;
      locked      <= (state_nxt == LOCK);
      err_pulse   <= err_inc;
      bus.ready_n <= ~(enable & ~throttle & (state_nxt != OFF));
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_chr;
    byte_inc  = 1'b0;
    wrap_inc  = 1'b0;
    err_inc   = 1'b0;
    case (state)
      OFF: begin
        if (enable)
          state_nxt = HUNT;
      end
      HUNT: begin
        if (accept && bus.port == FIRSTCHAR) begin
          state_nxt = LOCK;
          exp_nxt   = next_char(FIRSTCHAR);
          byte_inc  = 1'b1;
          wrap_inc  = (FIRSTCHAR == LASTCHAR);
        end
      end
      LOCK: begin
        if (accept) begin
          if (bus.port == exp_chr) begin
            exp_nxt  = next_char(bus.port);
            byte_inc = 1'b1;
            wrap_inc = (bus.port == LASTCHAR);
          end else begin
            err_inc = 1'b1;
            // A stray FIRSTCHAR is taken as the start of a fresh cycle.
            if (bus.port == FIRSTCHAR) begin
              exp_nxt  = next_char(FIRSTCHAR);
              byte_inc = 1'b1;
            end else begin
              state_nxt = HUNT;
            end
          end
        end
      end
      default: state_nxt = OFF;
    endcase
    // Disabling wins over every transition, but a byte accepted on this
    // edge has already been scored above.
    if (!enable)
      state_nxt = OFF;
  end

  sat_counter #(.CNTW(CNTW)) u_byte_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (byte_inc),
    .clr   (clear),
    .cnt   (byte_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_wrap_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (wrap_inc),
    .clr   (clear),
    .cnt   (wrap_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_err_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .inc   (err_inc),
    .clr   (clear),
    .cnt   (err_cnt)
  );

endmodule

// File: tb/tb_charchk.sv
// Directed bench for charchk: a wide-counter instance and a 4-bit-counter
// instance see identical link traffic from one upstream model.
module tb_charchk;
  import charchk_pkg::*;

  logic  clk = 1'b0;
  logic  n_rst = 1'b0;
  logic  valid_n = 1'b1;
  byte_t port_d = 8'h00;
  logic  enable = 1'b0;
  logic  throttle = 1'b0;
  logic  clear = 1'b0;

  logic        locked, err_pulse;
  logic [15:0] byte_cnt, wrap_cnt, err_cnt;
  logic        s_locked, s_err_pulse;
  logic [3:0]  s_byte_cnt, s_wrap_cnt, s_err_cnt;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  charchk_if bus ();
  charchk_if sbus ();

  assign bus.valid_n  = valid_n;
  assign bus.port     = port_d;
  assign sbus.valid_n = valid_n;
  assign sbus.port    = port_d;

  charchk #(.CNTW(16)) u_dut (
    .clk (clk), .n_rst (n_rst), .bus (bus),
    .enable (enable), .throttle (throttle), .clear (clear),
    .locked (locked), .err_pulse (err_pulse),
    .byte_cnt (byte_cnt), .wrap_cnt (wrap_cnt), .err_cnt (err_cnt)
  );

  charchk #(.CNTW(4)) u_sat (
    .clk (clk), .n_rst (n_rst), .bus (sbus),
    .enable (enable), .throttle (throttle), .clear (clear),
    .locked (s_locked), .err_pulse (s_err_pulse),
    .byte_cnt (s_byte_cnt), .wrap_cnt (s_wrap_cnt), .err_cnt (s_err_cnt)
  );

  always #5 clk = ~clk;

  // Upstream model: hold the byte until a handshake edge, then release.
  task automatic send(input byte_t c);
    bit hs = 1'b0;
    int n = 0;
    valid_n = 1'b0;
    port_d  = c;
    while (!hs && n < 100) begin
      hs = (bus.ready_n == 1'b0);
      @(posedge clk);
      @(negedge clk);
      n++;
      cyc++;
    end
    valid_n = 1'b1;
    if (!hs) begin
      total++;
      $display("FAIL send_timeout: byte %02h not accepted after %0d cycles", c, n);
    end
  endtask

  task automatic send_range(input byte_t lo, input byte_t hi);
    for (int c = lo; c <= hi; c++) send(byte_t'(c));
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.ready_n !== 1'b1) $display("FAIL rst_ready_n: got %b want 1", bus.ready_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL rst_locked: got %b want 0", locked); else passed++;
    total++; if (err_pulse !== 1'b0) $display("FAIL rst_err_pulse: got %b want 0", err_pulse); else passed++;
    total++; if ({byte_cnt, wrap_cnt, err_cnt} !== 48'd0)
      $display("FAIL rst_counters: got %0d/%0d/%0d want 0/0/0", byte_cnt, wrap_cnt, err_cnt); else passed++;
    n_rst = 1'b1;
    @(negedge clk);
    total++; if (bus.ready_n !== 1'b1) $display("FAIL off_ready_n: got %b want 1", bus.ready_n); else passed++;
  endtask

  task automatic test_lock_stream();
    enable = 1'b1;
    @(negedge clk);
    total++; if (bus.ready_n !== 1'b0) $display("FAIL enable_ready_n: got %b want 0", bus.ready_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL hunt_locked: got %b want 0", locked); else passed++;
    send("a");
    total++; if (locked !== 1'b1) $display("FAIL first_a_locked: got %b want 1", locked); else passed++;
    send_range("b", "z");
    send_range("a", "z");
    total++; if (byte_cnt !== 16'd52) $display("FAIL stream_byte_cnt: got %0d want 52", byte_cnt); else passed++;
    total++; if (wrap_cnt !== 16'd2) $display("FAIL stream_wrap_cnt: got %0d want 2", wrap_cnt); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL stream_err_cnt: got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_throttle();
    bit done = 1'b0;
    int c0 = cyc;
    fork
      begin
        send_range("a", "z");
        done = 1'b1;
      end
      begin
        while (!done) begin
          throttle = 1'b1;
          @(negedge clk);
          throttle = 1'b0;
          @(negedge clk);
          @(negedge clk);
        end
      end
    join
    throttle = 1'b0;
    total++; if (cyc - c0 <= 26) $display("FAIL throttle_stall: got %0d cycles want more than 26", cyc - c0); else passed++;
    total++; if (byte_cnt !== 16'd78) $display("FAIL throttle_byte_cnt: got %0d want 78", byte_cnt); else passed++;
    total++; if (wrap_cnt !== 16'd3) $display("FAIL throttle_wrap_cnt: got %0d want 3", wrap_cnt); else passed++;
    total++; if (err_cnt !== 16'd0) $display("FAIL throttle_err_cnt: got %0d want 0", err_cnt); else passed++;
  endtask

  task automatic test_error_hunt();
    pulse_clear();
    total++; if ({byte_cnt, wrap_cnt, err_cnt} !== 48'd0)
      $display("FAIL clear_counters: got %0d/%0d/%0d want 0/0/0", byte_cnt, wrap_cnt, err_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL clear_keeps_lock: got %b want 1", locked); else passed++;
    send("a");
    send("b");
    send("x");
    total++; if (err_pulse !== 1'b1) $display("FAIL err_pulse_x: got %b want 1", err_pulse); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL err_to_hunt: got %b want 0", locked); else passed++;
    send("y");
    total++; if (err_pulse !== 1'b0) $display("FAIL err_pulse_one_cycle: got %b want 0", err_pulse); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL hunt_drop_err_cnt: got %0d want 1", err_cnt); else passed++;
    send("a");
    send("b");
    total++; if (locked !== 1'b1) $display("FAIL relock: got %b want 1", locked); else passed++;
    total++; if (byte_cnt !== 16'd4) $display("FAIL relock_byte_cnt: got %0d want 4", byte_cnt); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL relock_err_cnt: got %0d want 1", err_cnt); else passed++;
  endtask

  task automatic test_resync();
    send_range("c", "z");
    pulse_clear();
    send("a");
    send("b");
    send("a");
    total++; if (err_pulse !== 1'b1) $display("FAIL resync_err_pulse: got %b want 1", err_pulse); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL resync_locked: got %b want 1", locked); else passed++;
    send("b");
    total++; if (byte_cnt !== 16'd4) $display("FAIL resync_byte_cnt: got %0d want 4", byte_cnt); else passed++;
    total++; if (err_cnt !== 16'd1) $display("FAIL resync_err_cnt: got %0d want 1", err_cnt); else passed++;
    total++; if (locked !== 1'b1) $display("FAIL resync_still_locked: got %b want 1", locked); else passed++;
  endtask

  task automatic test_saturation();
    pulse_clear();
    send_range("c", "v");
    total++; if (s_byte_cnt !== 4'd15) $display("FAIL sat_byte_cnt: got %0d want 15", s_byte_cnt); else passed++;
    total++; if (byte_cnt !== 16'd20) $display("FAIL wide_byte_cnt: got %0d want 20", byte_cnt); else passed++;
    clear = 1'b1;
    send("w");
    clear = 1'b0;
    total++; if (s_byte_cnt !== 4'd0) $display("FAIL clear_beats_inc_small: got %0d want 0", s_byte_cnt); else passed++;
    total++; if (byte_cnt !== 16'd0) $display("FAIL clear_beats_inc_wide: got %0d want 0", byte_cnt); else passed++;
    send("x");
    total++; if (byte_cnt !== 16'd1) $display("FAIL clear_keeps_exp: got %0d want 1", byte_cnt); else passed++;
    total++; if (s_err_cnt !== 4'd0) $display("FAIL sat_err_cnt: got %0d want 0", s_err_cnt); else passed++;
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    send("y");
    total++; if (bus.ready_n !== 1'b1) $display("FAIL drop_ready_n: got %b want 1", bus.ready_n); else passed++;
    total++; if (locked !== 1'b0) $display("FAIL drop_locked: got %b want 0", locked); else passed++;
    total++; if (byte_cnt !== 16'd2) $display("FAIL drop_last_byte_counted: got %0d want 2", byte_cnt); else passed++;
    valid_n = 1'b0;
    port_d  = "z";
    repeat (3) @(negedge clk);
    valid_n = 1'b1;
    total++; if (byte_cnt !== 16'd2 || bus.ready_n !== 1'b1)
      $display("FAIL off_holds: got cnt %0d ready_n %b want cnt 2 ready_n 1", byte_cnt, bus.ready_n); else passed++;
    enable = 1'b1;
    send("z");
    total++; if (locked !== 1'b0) $display("FAIL reenable_no_lock: got %b want 0", locked); else passed++;
    total++; if ({byte_cnt, wrap_cnt, err_cnt} !== {16'd2, 16'd0, 16'd0})
      $display("FAIL reenable_counters: got %0d/%0d/%0d want 2/0/0", byte_cnt, wrap_cnt, err_cnt); else passed++;
    send("a");
    total++; if (locked !== 1'b1) $display("FAIL reenable_lock_on_a: got %b want 1", locked); else passed++;
    total++; if (byte_cnt !== 16'd3) $display("FAIL reenable_byte_cnt: got %0d want 3", byte_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    valid_n = 1'b0;
    port_d  = "b";
    #2;
    n_rst = 1'b0;
    #1;
    total++; if ({byte_cnt, wrap_cnt, err_cnt} !== 48'd0)
      $display("FAIL midrst_counters: got %0d/%0d/%0d want 0/0/0", byte_cnt, wrap_cnt, err_cnt); else passed++;
    total++; if (bus.ready_n !== 1'b1 || locked !== 1'b0)
      $display("FAIL midrst_ctrl: got ready_n %b locked %b want 1 0", bus.ready_n, locked); else passed++;
    repeat (2) @(negedge clk);
    valid_n = 1'b1;
    n_rst = 1'b1;
    @(negedge clk);
    total++; if (byte_cnt !== 16'd0) $display("FAIL midrst_no_partial: got %0d want 0", byte_cnt); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lock_stream();
    test_throttle();
    test_error_hunt();
    test_resync();
    test_saturation();
    test_enable_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/charchk.md
Name: charchk

Overview:
- Consumer and checker for the active-low valid/ready byte stream driven by the character generator.
- Asserts ready_n to pull bytes and accepts one byte per handshake.
- Locks onto the repeating FIRSTCHAR..LASTCHAR sequence and counts good bytes, sequence wraps and sequence errors.
- Sits at the far end of the generator link for board self-test; also allows backpressure injection.

Parameters:
- FIRSTCHAR, "a", first character of the sequence and the resync character.
- LASTCHAR, "z", last character; it wraps to FIRSTCHAR. Must satisfy LASTCHAR >= FIRSTCHAR.
- CNTW, 16, width of every statistics counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- n_rst  in  1  asynchronous, active-low reset.
- valid_n  in  1  upstream data valid, active low.
- port  in  8  upstream data byte.
- ready_n  out  1  this block ready to accept, active low; registered.
- enable  in  1  high = checker runs and requests data.
- throttle  in  1  high = withhold ready (backpressure injection).
- clear  in  1  synchronous clear of all counters.
- locked  out  1  high while in LOCK.
- err_pulse  out  1  one-cycle pulse per sequence error.
- byte_cnt  out  CNTW  good bytes received in LOCK; saturating.
- wrap_cnt  out  CNTW  LASTCHAR bytes received correctly in LOCK; saturating.
- err_cnt  out  CNTW  sequence errors; saturating.

Behaviour:
- Transfer rule: a byte is accepted at a posedge only when valid_n==0 and ready_n==0 at that edge.
  - A byte presented while ready_n==1 is not consumed.
  - The upstream re-presents it after ready_n returns low; this is not an error.
- Reset (n_rst low, asynchronous):
  - ready_n=1; state OFF; locked=0; err_pulse=0.
  - All counters 0; expected-char register exp=FIRSTCHAR.
- ready_n is registered: ready_n <= ~(enable & ~throttle & ~n_state_is_OFF_next).
  - One cycle of latency from enable/throttle change to ready_n.
- States:
  - OFF: entered from any state when enable==0. ready_n driven high. Accepted bytes are impossible; valid_n is ignored.
  - OFF -> HUNT: on the edge where enable==1.
  - HUNT: each accepted byte is compared with FIRSTCHAR.
    - Equal -> LOCK, exp=next(FIRSTCHAR), byte_cnt+1 (+ wrap_cnt+1 if FIRSTCHAR==LASTCHAR).
    - Not equal: stay in HUNT, no counters change.
  - LOCK: each accepted byte is compared with exp.
    - Equal: exp=next(byte), byte_cnt+1; if byte==LASTCHAR, wrap_cnt+1.
    - Not equal: err_cnt+1 and err_pulse=1 next cycle. Then:
      - If byte==FIRSTCHAR: stay in LOCK, exp=next(FIRSTCHAR), byte_cnt+1 (immediate resync).
      - Otherwise -> HUNT.
- next(c) = FIRSTCHAR if c==LASTCHAR, else c+1 (8-bit).
- locked = (state==LOCK), registered with the state.
- Counters:
  - Saturate at all-ones; no wrap.
  - clear zeroes all three counters at the edge and takes priority over any increment in the same cycle.
  - clear does not change the state or exp.
- enable falling while in LOCK:
  - -> OFF at that edge; a byte accepted in that same edge is still checked and counted.
  - Re-enabling enters HUNT; lock is never retained across OFF.
- throttle only gates ready_n; it has no effect on the state or exp.
- Reset mid-transfer: everything returns to reset values immediately; no partial byte is counted.

Decomposition:
- Shared package:
  - active-low truth constants nT=1'b0 and nF=1'b1.
  - byte type (8-bit) shared with the generator.
  - state enum {OFF, HUNT, LOCK}.
- Sub-module sat_counter (CNTW, inc, clr) instantiated three times.
- FSM, exp register and the ready_n register stay in charchk.

Test Plan:
- Reset, then enable=1, generator free-running with "a".."z":
  - ready_n low 1 cycle after enable; locked after the first "a".
  - After 52 bytes: byte_cnt=52, wrap_cnt=2, err_cnt=0.
- Throttle 1 cycle on / 2 cycles off during the stream:
  - The re-presented byte is accepted once; err_cnt stays 0.
  - byte_cnt equals the number of handshakes.
- Force stream "a","b","x","y","a","b" (upstream model):
  - err_cnt=1, err_pulse on the "x" accept+1.
  - HUNT drops "y"; relocks on "a"; byte_cnt=4.
- Stream "a","b","a","b":
  - Error on the second "a", immediate resync with no HUNT; err_cnt=1, byte_cnt=4, locked stays 1.
- CNTW=4, 20 good bytes:
  - byte_cnt saturates at 15.
  - clear asserted together with a good byte -> byte_cnt=0.
- enable dropped mid-stream:
  - ready_n high next cycle, locked=0, counters hold.
  - Re-enable: no lock until the next "a".
